// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- LEGv8 instruction-fetch stage.
//
// Owns the program counter and fetches instructions over a req/ack handshake
// that tolerates any memory latency. Fetched words are delivered to decode
// through the IF/ID pipeline register. A one-entry skid buffer absorbs a word
// that returns while decode is stalled. Redirects from a resolved branch
// flush IF/ID. A redirect that arrives while a request is outstanding is
// parked until that request completes.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   imem_req       instruction memory request (FETCH and DRAIN states)
//   imem_addr      fetch address, word aligned (equals pc)
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     instruction word, valid with imem_ack
//   stall          decode cannot take a new instruction
//   redirect_valid taken branch resolved downstream
//   redirect_pc    branch target; bits [1:0] are ignored
//   if_id_valid    IF/ID holds a live instruction
//   if_id_pc       PC of the IF/ID instruction
//   if_id_inst     IF/ID instruction word
//   if_id_opcode   if_id_inst[31:21], for the control unit
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_id_valid,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [INST_WIDTH-1:0] if_id_inst,
  output logic [10:0]           if_id_opcode
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic [INST_WIDTH-1:0] skid_inst;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pc_next_seq;
  logic                  load_fetch;
  logic                  load_skid;

  // Decode can take a word when it is not stalled or IF/ID is empty.
  assign accept      = !stall || !if_id_valid;
  assign target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  // Wraps modulo 2^ADDR_WIDTH.
  assign pc_next_seq = pc + ADDR_WIDTH'(4);

  // A redirect in the same cycle kills either source of a new instruction.
  assign load_fetch = (state == FETCH) && imem_ack && !redirect_valid && accept;
  assign load_skid  = (state == HOLD) && !redirect_valid && accept;

  // The request is a pure decode of the state register. pc only changes on an
  // ack or outside a request, so the address stays stable while req is high.
  assign imem_req     = (state == FETCH) || (state == DRAIN);
  assign imem_addr    = pc;
  assign if_id_opcode = if_id_inst[31:21];

  // NOTE: every register here uses non-blocking assignment, so each branch
  // reads the pre-edge values of pc, state and if_id_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      // NOTE: the skid data registers are reset as well. They are small, and
      // clearing them keeps the datapath free of X values after reset.
      skid_pc     <= '0;
      skid_inst   <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
    end else begin
      // ---------------- fetch control ----------------
      unique case (state)
        IDLE: begin
          // A stale ack from before reset is ignored here.
          state <= FETCH;
        end

        FETCH: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              pc <= target;               // returned word is on the wrong path
            end else if (accept) begin
              pc <= pc_next_seq;
            end else begin
              skid_pc   <= pc;
              skid_inst <= imem_rdata;
              pc        <= pc_next_seq;
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            // The outstanding address must not move. Park the target.
            pend_pc <= target;
            state   <= DRAIN;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc    <= target;              // skid contents are dropped
            state <= FETCH;
          end else if (accept) begin
            state <= FETCH;
          end
        end

        DRAIN: begin
          if (imem_ack) begin
            // The latest target wins, including one on the ack cycle itself.
            pc    <= redirect_valid ? target : pend_pc;
            state <= FETCH;
          end else if (redirect_valid) begin
            pend_pc <= target;
          end
        end

        default: state <= IDLE;
      endcase

      // ---------------- IF/ID register ----------------
      if (redirect_valid) begin
        if_id_valid <= 1'b0;
      end else if (stall && if_id_valid) begin
        if_id_valid <= 1'b1;              // hold every field
      end else if (load_fetch) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc;
        if_id_inst  <= imem_rdata;
      end else if (load_skid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= skid_pc;
        if_id_inst  <= skid_inst;
      end else begin
        if_id_valid <= 1'b0;              // bubble; payload keeps old value
      end
    end
  end

endmodule
